shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares one combinational barrel_shifter instance between two requesters: port 0 is the execute stage, port 1 is the multi-cycle mul/div/bit-manip unit.
- Per-port valid/ready request handshake; round-robin grant.
- Registers a single result with a requester ID and holds it under backpressure.
- Filters illegal shift opcodes so the shifter never sees an undefined op.

Parameters:
- CNT_W, 16, width of the per-port saturating served-operation counters.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_data  in  32  port 0 operand.
- req0_sa  in  5  port 0 shift amount.
- req0_op  in  3  port 0 shift opcode.
- req1_valid  in  1  port 1 request valid.
- req1_ready  out  1  port 1 request accepted this cycle.
- req1_data  in  32  port 1 operand.
- req1_sa  in  5  port 1 shift amount.
- req1_op  in  3  port 1 shift opcode.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_id  out  1  requester that owns the result.
- rsp_data  out  32  shift result.
- rsp_err  out  1  the opcode was illegal; rsp_data = operand unchanged.
- cnt0  out  CNT_W  number of port 0 ops accepted, saturating.
- cnt1  out  CNT_W  number of port 1 ops accepted, saturating.

Behaviour:
- Opcodes:
  - SLL = 001, SRL = 010, SRA = 100, ROR = 110, ROL = 111.
  - Any other opcode is illegal.
- Reset: rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_err = 0, cnt0 = cnt1 = 0, rr_ptr = 0 (port 0 preferred).
- States are encoded by rsp_valid:
  - EMPTY (rsp_valid = 0).
  - FULL (rsp_valid = 1).
- Slot free: free = !rsp_valid || rsp_ready.
- Grant (combinational):
  - Only one port valid: that port is granted.
  - Both ports valid: the port at rr_ptr is granted.
  - No port valid: no grant.
- reqX_ready = granted(X) && free. At most one ready is high per cycle. Ready may depend on reqX_valid and rsp_ready.
- Acceptance (valid && ready at an edge):
  - Granted operand, sa and op drive the shifter.
  - Illegal op: the shifter is driven with SLL and sa = 0, and the register captures rsp_err = 1.
  - The result register captures data, ID and err; rsp_valid = 1.
  - rr_ptr becomes the other port.
  - The accepted port's counter increments, saturating at all-ones.
- Latency: one cycle. Result is visible the cycle after acceptance.
- Throughput: one op per cycle while rsp_ready = 1.
- Transitions:
  - FULL with rsp_ready = 1 and a new acceptance: stays FULL with the new result, with no bubble.
  - FULL with rsp_ready = 1 and no acceptance: goes to EMPTY.
  - FULL with rsp_ready = 0: rsp_* hold stable and both readys are 0.
- rr_ptr changes only on a contended or uncontended acceptance, never on idle cycles.
- Arithmetic (sa is taken mod 32, 5 bits):
  - SLL and SRL zero-fill.
  - SRA sign-fills from bit 31.
  - ROR and ROL are 32-bit rotates.
  - sa = 0 passes the operand unchanged for every op.
- Requester obligations (assertion-checked): once reqX_valid is high without ready, it stays high and its payload stays stable.
- Reset mid-operation: a pending result is discarded (rsp_valid = 0 next cycle); no ready is asserted during rst.
- Counter saturation: at all-ones the counter holds; no wrap.

Decomposition:
- Package shift_pkg holds:
  - the five opcode constants;
  - the function is_legal_op(op);
  - the ID constants PORT_EXE = 0 and PORT_MDU = 1.
- Sub-modules:
  - One instance of the existing barrel_shifter.
  - One natural sub-module rr_arb2: a 2-way round-robin grant with its pointer register. Inputs are valid[1:0] and an advance strobe; output is grant[1:0].
- Target size: about 150–200 lines.

Test Plan:
1. Port 0 alone, op SLL, data 0x0000_0001, sa = 4, rsp_ready = 1 → next cycle rsp_valid = 1, rsp_id = 0, rsp_data = 0x0000_0010, rsp_err = 0, cnt0 = 1.
2. Each op on port 1, all with rsp_ready = 1:
   - ROR on 0x0000_0001, sa = 1 → rsp_data = 0x8000_0000.
   - SRA on 0x8000_0000, sa = 31 → 0xFFFF_FFFF.
   - ROL on 0x8000_0001, sa = 4 → 0x0000_0018.
   - SRL on 0x8000_0000, sa = 31 → 0x0000_0001.
3. Both ports valid for 4 cycles with rsp_ready = 1 → rsp_id sequence 0, 1, 0, 1; cnt0 = cnt1 = 2; no bubbles.
4. Backpressure: result FULL, rsp_ready = 0 for 3 cycles while both ports are valid → both readys = 0 and rsp_* stable. Then rsp_ready = 1 → the next grant is accepted in the same cycle.
5. Illegal op 3'b011 with data 0xDEAD_BEEF, sa = 7 → rsp_data = 0xDEAD_BEEF, rsp_err = 1. The next legal op returns rsp_err = 0.
6. rst pulsed while FULL and both ports valid → after reset rsp_valid = 0, cnt0 = cnt1 = 0, and the first contended grant goes to port 0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: opcodes, requester IDs,
// result-slot state encoding and the opcode legality check.
package shift_pkg;

    // Shift opcodes understood by barrel_shifter.
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b110;
    localparam logic [2:0] OP_ROL = 3'b111;

    // Requester IDs as reported on rsp_id.
    localparam logic PORT_EXE = 1'b0;
    localparam logic PORT_MDU = 1'b1;

    // The result slot state is exactly the rsp_valid bit.
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    // One request payload as seen by the shared shifter.
    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  sa;
        logic [2:0]  op;
    } shift_req_t;

    // True for the five opcodes the shifter defines.
    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        case (op)
            OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_ROL: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational 32-bit shifter/rotator. Shift amount is used modulo 32,
// so sa = 0 returns the operand unchanged for every opcode.
module barrel_shifter
    import shift_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [4:0]  i_sa,
    input  logic [2:0]  i_op,
    output logic [31:0] o_data
);

    logic [31:0] w_ror;
    logic [31:0] w_rol;

    // Rotates: each output bit picks an input bit whose 5-bit index wraps naturally.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rot
            localparam logic [4:0] BIT_IDX = 5'(gi);
            assign w_ror[gi] = i_data[BIT_IDX + i_sa];
            assign w_rol[gi] = i_data[BIT_IDX - i_sa];
        end
    endgenerate

    // Opcode select; undefined opcodes fall through as a pass-through.
    always_comb begin
        o_data = i_data;
        case (i_op)
            OP_SLL:  o_data = i_data << i_sa;
            OP_SRL:  o_data = i_data >> i_sa;
            OP_SRA:  o_data = $signed(i_data) >>> i_sa;
            OP_ROR:  o_data = w_ror;
            OP_ROL:  o_data = w_rol;
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The pointer names the preferred port when both
// request; on an advance strobe it moves to the port that was not granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic r_ptr;

    // Grant: a lone requester wins, a contended cycle goes to the pointer.
    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    // Pointer moves only when a grant is actually consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= o_grant[0];
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrel_shifter between the execute stage (port 0) and the
// mul/div/bit-manip unit (port 1). One registered result slot with ID and
// error flag; the slot holds under backpressure and refills without a bubble.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_data,
    input  logic [4:0]       req0_sa,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_data,
    input  logic [4:0]       req1_sa,
    input  logic [2:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;

    logic [1:0]  w_valid;
    logic [1:0]  w_grant;
    logic [1:0]  w_ready;
    logic [1:0]  w_acc;
    logic        w_accept;
    logic        w_free;
    logic        w_legal;
    shift_req_t  w_req0;
    shift_req_t  w_req1;
    shift_req_t  w_sel;
    logic [2:0]  w_sh_op;
    logic [4:0]  w_sh_sa;
    logic [31:0] w_sh_out;

    assign w_valid = {req1_valid, req0_valid};
    assign w_req0  = '{data: req0_data, sa: req0_sa, op: req0_op};
    assign w_req1  = '{data: req1_data, sa: req1_sa, op: req1_op};

    // Slot can take a new result if empty or being drained this cycle.
    assign w_free  = (r_rsp_valid == ST_EMPTY) || rsp_ready;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (w_valid),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    // Ready is suppressed while in reset so nothing is accepted and lost.
    assign w_ready    = w_grant & {2{w_free && !rst}};
    assign w_acc      = w_valid & w_ready;
    assign w_accept   = |w_acc;
    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];

    // Granted payload; illegal opcodes become a zero-distance SLL (identity).
    assign w_sel   = w_grant[1] ? w_req1 : w_req0;
    assign w_legal = is_legal_op(w_sel.op);
    assign w_sh_op = w_legal ? w_sel.op : OP_SLL;
    assign w_sh_sa = w_legal ? w_sel.sa : 5'd0;

    barrel_shifter u_shifter (
        .i_data (w_sel.data),
        .i_sa   (w_sh_sa),
        .i_op   (w_sh_op),
        .o_data (w_sh_out)
    );

    // Result slot: capture on accept, drain on consumer ready, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= ST_EMPTY;
            r_rsp_id    <= PORT_EXE;
            r_rsp_data  <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= ST_FULL;
            r_rsp_id    <= w_grant[1] ? PORT_MDU : PORT_EXE;
            r_rsp_data  <= w_sh_out;
            r_rsp_err   <= !w_legal;
        end else if (rsp_ready) begin
            r_rsp_valid <= ST_EMPTY;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

    // Per-port served-operation counters, saturating at all-ones.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_acc[gi] && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    assign cnt0 = g_cnt[0].r_cnt;
    assign cnt1 = g_cnt[1].r_cnt;

    // Requesters must hold valid and payload until accepted.
    a_req0_hold: assert property (@(posedge clk) disable iff (rst)
        (req0_valid && !req0_ready) |=> (req0_valid && $stable(w_req0)));
    a_req1_hold: assert property (@(posedge clk) disable iff (rst)
        (req1_valid && !req1_ready) |=> (req1_valid && $stable(w_req1)));

    // The shared shifter can serve only one port per cycle.
    a_one_ready: assert property (@(posedge clk) !(req0_ready && req1_ready));

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: per-port request queues drive the
// DUT, a reference model predicts readys/counters, and a scoreboard queue
// holds the expected result for each accepted request.
module tb_shift_arbiter;
    import shift_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready;
    logic [31:0]   req0_data;
    logic [4:0]    req0_sa;
    logic [2:0]    req0_op;
    logic          req1_valid, req1_ready;
    logic [31:0]   req1_data;
    logic [4:0]    req1_sa;
    logic [2:0]    req1_op;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0]   rsp_data;
    logic [CW-1:0] cnt0, cnt1;

    always #5 clk = ~clk;

    shift_arbiter #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_sa    (req0_sa),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_sa    (req1_sa),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    typedef struct {
        logic [31:0] d;
        logic [4:0]  sa;
        logic [2:0]  op;
    } req_s;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
    } rsp_s;

    req_s pq0[$];
    req_s pq1[$];
    rsp_s sb[$];

    logic          m_full;
    logic          m_ptr;
    logic [CW-1:0] m_cnt0, m_cnt1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Bit-by-bit reference shifter.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sa,
                                              input logic [2:0] op);
        logic [31:0] r;
        int s;
        s = int'(sa);
        for (int i = 0; i < 32; i++) begin
            case (op)
                3'b001:  r[i] = (i >= s) ? d[i - s] : 1'b0;
                3'b010:  r[i] = (i + s < 32) ? d[i + s] : 1'b0;
                3'b100:  r[i] = (i + s < 32) ? d[i + s] : d[31];
                3'b110:  r[i] = d[(i + s) % 32];
                3'b111:  r[i] = d[(i - s + 32) % 32];
                default: r[i] = d[i];
            endcase
        end
        return r;
    endfunction

    function automatic logic ref_legal(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b010) || (op == 3'b100) ||
               (op == 3'b110) || (op == 3'b111);
    endfunction

    function automatic rsp_s predict(input logic id, input req_s q);
        rsp_s e;
        e.id   = id;
        e.err  = !ref_legal(q.op);
        e.data = e.err ? q.d : ref_shift(q.d, q.sa, q.op);
        return e;
    endfunction

    task automatic push_req(input int port, input logic [2:0] op, input logic [31:0] d,
                            input logic [4:0] sa);
        req_s q;
        q.d = d; q.sa = sa; q.op = op;
        if (port == 0) pq0.push_back(q);
        else           pq1.push_back(q);
    endtask

    task automatic model_reset();
        m_full = 1'b0; m_ptr = 1'b0; m_cnt0 = '0; m_cnt1 = '0;
        sb.delete();
    endtask

    // One clock cycle: drive from the queues, check against the model, advance.
    task automatic cycle();
        logic v0, v1, g0, g1, fr, e0, e1;
        rsp_s e;
        v0 = (pq0.size() > 0);
        v1 = (pq1.size() > 0);
        req0_valid = v0;
        req0_data  = v0 ? pq0[0].d  : 32'd0;
        req0_sa    = v0 ? pq0[0].sa : 5'd0;
        req0_op    = v0 ? pq0[0].op : 3'd0;
        req1_valid = v1;
        req1_data  = v1 ? pq1[0].d  : 32'd0;
        req1_sa    = v1 ? pq1[0].sa : 5'd0;
        req1_op    = v1 ? pq1[0].op : 3'd0;
        #1;
        g0 = v0 && (!v1 || !m_ptr);
        g1 = v1 && (!v0 || m_ptr);
        fr = !m_full || rsp_ready;
        e0 = g0 && fr && !rst;
        e1 = g1 && fr && !rst;
        check_val("req0_ready", 32'(req0_ready), 32'(e0));
        check_val("req1_ready", 32'(req1_ready), 32'(e1));
        check_val("rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (m_full) begin
            e = sb[0];
            check_val("rsp_id", 32'(rsp_id), 32'(e.id));
            check_val("rsp_data", rsp_data, e.data);
            check_val("rsp_err", 32'(rsp_err), 32'(e.err));
        end
        check_val("cnt0", 32'(cnt0), 32'(m_cnt0));
        check_val("cnt1", 32'(cnt1), 32'(m_cnt1));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_full && rsp_ready) begin
                e = sb.pop_front();
                $display("rsp   id=%0d data=%h err=%0d", e.id, e.data, e.err);
                m_full = 1'b0;
            end
            if (e0 || e1) begin
                e = e1 ? predict(1'b1, pq1[0]) : predict(1'b0, pq0[0]);
                $display("accept port=%0d expect data=%h err=%0d", e.id, e.data, e.err);
                sb.push_back(e);
                m_full = 1'b1;
                m_ptr  = e0;
                if (e0) begin
                    if (m_cnt0 != '1) m_cnt0 = m_cnt0 + 1'b1;
                    void'(pq0.pop_front());
                end else begin
                    if (m_cnt1 != '1) m_cnt1 = m_cnt1 + 1'b1;
                    void'(pq1.pop_front());
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_data = '0; req0_sa = '0; req0_op = '0;
        req1_valid = 1'b0; req1_data = '0; req1_sa = '0; req1_op = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        // Reset state is checked while rst is still high.
        cycle();
        rst = 1'b0;
        rsp_ready = 1'b1;

        // Port 0 alone, SLL.
        push_req(0, OP_SLL, 32'h0000_0001, 5'd4);
        run(3);

        // Each op on port 1.
        push_req(1, OP_ROR, 32'h0000_0001, 5'd1);
        push_req(1, OP_SRA, 32'h8000_0000, 5'd31);
        push_req(1, OP_ROL, 32'h8000_0001, 5'd4);
        push_req(1, OP_SRL, 32'h8000_0000, 5'd31);
        push_req(1, OP_SLL, 32'h1234_5678, 5'd0);
        run(7);

        // Fresh contention: alternating grants, no bubbles.
        rst = 1'b1; cycle(); rst = 1'b0;
        push_req(0, OP_SLL, 32'h0000_00F0, 5'd3);
        push_req(0, OP_SRL, 32'hF000_0000, 5'd8);
        push_req(1, OP_SRA, 32'hF000_0000, 5'd8);
        push_req(1, OP_ROR, 32'h0000_00FF, 5'd4);
        run(6);

        // Backpressure with both ports pending, then release.
        push_req(0, OP_ROL, 32'hA5A5_0000, 5'd16);
        push_req(0, OP_SLL, 32'h0000_0003, 5'd30);
        push_req(1, OP_SRL, 32'hFFFF_FFFF, 5'd1);
        push_req(1, OP_SRA, 32'h7FFF_FFFF, 5'd5);
        cycle();
        rsp_ready = 1'b0;
        run(3);
        rsp_ready = 1'b1;
        run(6);

        // Illegal op then a legal one.
        push_req(0, 3'b011, 32'hDEAD_BEEF, 5'd7);
        push_req(0, OP_SLL, 32'hDEAD_BEEF, 5'd4);
        push_req(1, 3'b000, 32'h1111_2222, 5'd9);
        push_req(1, 3'b101, 32'h3333_4444, 5'd0);
        run(7);

        // Reset while FULL and both ports valid.
        push_req(0, OP_SRL, 32'h0000_8000, 5'd15);
        push_req(0, OP_SLL, 32'h0000_0001, 5'd31);
        push_req(1, OP_ROR, 32'h8765_4321, 5'd12);
        push_req(1, OP_ROL, 32'h8765_4321, 5'd12);
        cycle();
        rsp_ready = 1'b0;
        cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        rsp_ready = 1'b1;
        run(6);

        // Counter saturation on port 1.
        for (int i = 0; i < 20; i++) push_req(1, OP_ROL, 32'(i), 5'(i));
        run(23);

        // Random mix with random backpressure.
        for (int i = 0; i < 40; i++) begin
            push_req(int'($urandom_range(0, 1)), 3'($urandom), $urandom, 5'($urandom));
        end
        for (int i = 0; i < 120; i++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rsp_ready = 1'b1;
        run(4);
        check_val("drained", 32'(pq0.size() + pq1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
